// File: rtl/audio_i2s_transmitter.sv
// I2S serialiser for 16-bit stereo PCM, with a one-frame holding register and underrun counter.
// Define AUDIO_VOLUME_EN to add a 3-bit volume input that is applied to each frame as it is loaded.
module audio_i2s_transmitter #(
  parameter int LRCK_LOG2 = 11,
  parameter int MCLK_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] audio_left,
  input  logic [15:0] audio_right,
  input  logic        sample_valid,
`ifdef AUDIO_VOLUME_EN
  input  logic [2:0]  volume,
`endif
  output logic        sample_ready,
  output logic        audio_mclk,
  output logic        audio_lrck,
  output logic        audio_sck,
  output logic        audio_sdin,
  output logic        underrun,
  output logic [7:0]  underrun_cnt
);

  // 32 SCK periods per frame; MCLK_LOG2 must be below SCK_LOG2.
  localparam int SCK_LOG2 = LRCK_LOG2 - 5;

  logic [LRCK_LOG2-1:0] div_cnt_q, div_cnt_d;
  logic [31:0]          hold_q, hold_d;
  logic                 full_q, full_d;
  logic [31:0]          shift_q, shift_d;
  logic                 sdin_q, sdin_d;
  logic                 underrun_q, underrun_d;
  logic [7:0]           underrun_cnt_q, underrun_cnt_d;

  logic        fb;
  logic        slot_edge;
  logic        accept;
  logic [31:0] load_frame;

  assign fb        = &div_cnt_q;
  assign slot_edge = &div_cnt_q[SCK_LOG2-1:0];

  // Handshake: a frame transfers on any clk edge where sample_valid && sample_ready.
  // sample_ready is high when the holding register is empty or is being drained
  // at this frame boundary; the producer holds its data stable while valid && !ready.
  assign sample_ready = reset && (!full_q || fb);
  assign accept       = sample_valid && sample_ready;

`ifdef AUDIO_VOLUME_EN
  function automatic logic [15:0] scale(input logic [15:0] x, input logic [2:0] v);
    if (v == 3'd0) return 16'h0000;
    return 16'($signed(x) >>> (3'd7 - v));
  endfunction

  assign load_frame = {scale(hold_q[31:16], volume), scale(hold_q[15:0], volume)};
`else
  assign load_frame = hold_q;
`endif

  always_comb begin
    div_cnt_d      = div_cnt_q + 1'b1;
    hold_d         = hold_q;
    full_d         = full_q;
    shift_d        = shift_q;
    sdin_d         = sdin_q;
    underrun_d     = 1'b0;
    underrun_cnt_d = underrun_cnt_q;

    if (fb) begin
      // After 31 shifts the bit left at the top is the ending frame's R[0],
      // which becomes slot 0 of the next frame (I2S one-bit delay).
      sdin_d  = shift_q[31];
      shift_d = full_q ? load_frame : 32'h0;
      full_d  = accept;
      if (accept) hold_d = {audio_left, audio_right};
      if (!full_q) begin
        underrun_d = 1'b1;
        if (underrun_cnt_q != 8'hFF) underrun_cnt_d = underrun_cnt_q + 8'd1;
      end
    end else begin
      if (slot_edge) begin
        sdin_d  = shift_q[31];
        shift_d = {shift_q[30:0], 1'b0};
      end
      if (accept) begin
        hold_d = {audio_left, audio_right};
        full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_q      <= '0;
      hold_q         <= 32'h0;
      full_q         <= 1'b0;
      shift_q        <= 32'h0;
      sdin_q         <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= 8'h00;
    end else begin
      div_cnt_q      <= div_cnt_d;
      hold_q         <= hold_d;
      full_q         <= full_d;
      shift_q        <= shift_d;
      sdin_q         <= sdin_d;
      underrun_q     <= underrun_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign audio_mclk   = div_cnt_q[MCLK_LOG2-1];
  assign audio_sck    = div_cnt_q[SCK_LOG2-1];
  assign audio_lrck   = div_cnt_q[LRCK_LOG2-1];
  assign audio_sdin   = sdin_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_audio_i2s_transmitter.sv
// Self-checking bench for audio_i2s_transmitter, run with a short frame so 300 starved frames stay quick.
module tb_audio_i2s_transmitter;

  localparam int LRCK_LOG2 = 7;
  localparam int MCLK_LOG2 = 1;
  localparam int SCK_LOG2  = LRCK_LOG2 - 5;
  localparam int FRAME     = 1 << LRCK_LOG2;
  localparam int SCK_PER   = 1 << SCK_LOG2;

  logic        clk;
  logic        reset;
  logic [15:0] audio_left;
  logic [15:0] audio_right;
  logic        sample_valid;
  logic        sample_ready;
  logic        audio_mclk;
  logic        audio_lrck;
  logic        audio_sck;
  logic        audio_sdin;
  logic        underrun;
  logic [7:0]  underrun_cnt;
`ifdef AUDIO_VOLUME_EN
  logic [2:0]  volume;
`endif

  audio_i2s_transmitter #(.LRCK_LOG2(LRCK_LOG2), .MCLK_LOG2(MCLK_LOG2)) dut (
    .clk          (clk),
    .reset        (reset),
    .audio_left   (audio_left),
    .audio_right  (audio_right),
    .sample_valid (sample_valid),
`ifdef AUDIO_VOLUME_EN
    .volume       (volume),
`endif
    .sample_ready (sample_ready),
    .audio_mclk   (audio_mclk),
    .audio_lrck   (audio_lrck),
    .audio_sck    (audio_sck),
    .audio_sdin   (audio_sdin),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  // ---------------- clock / reset / cycle reference ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clk edges since reset release; equals the expected divider value modulo FRAME.
  int cyc = 0;
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic wait_div(input int d);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((cyc % FRAME) != d && k < FRAME + 4);
    if ((cyc % FRAME) != d) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_div: divider %0d never reached, got %0d", d, cyc % FRAME);
    end
  endtask

  // Called at a negedge; returns once the transfer edge has passed.
  task automatic push(input logic [15:0] l, input logic [15:0] r, output int acc_div);
    int k;
    audio_left   = l;
    audio_right  = r;
    sample_valid = 1'b1;
    k = 0;
    while (!sample_ready && k < FRAME + 4) begin
      @(negedge clk);
      k++;
    end
    acc_div = cyc % FRAME;
    if (!sample_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL push: sample_ready stayed low for %0d cycles", k);
    end
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // Samples the middle of each slot of the next frame: w = {slot0, slot1..slot31}.
  task automatic capture_frame(output logic [31:0] w);
    wait_div(SCK_PER / 2);
    for (int k = 0; k < 32; k++) begin
      w[31-k] = audio_sdin;
      if (k < 31) repeat (SCK_PER) @(negedge clk);
    end
  endtask

  task automatic check_frame(input string name);
    logic [31:0] got;
    logic [31:0] exp;
    capture_frame(got);
    exp = exp_q.pop_front();
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: sdin frame got %08h expected %08h", name, got, exp);
    end
  endtask

  task automatic check_cnt(input string name, input logic [7:0] exp);
    n_cmp++;
    if (underrun_cnt !== exp) begin
      n_err++;
      $display("FAIL %s: underrun_cnt got %0d expected %0d", name, underrun_cnt, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    logic [6:0] got;
    got = {sample_ready, audio_mclk, audio_lrck, audio_sck, audio_sdin, underrun, |underrun_cnt};
    n_cmp++;
    if (got !== 7'b0) begin
      n_err++;
      $display("FAIL %s: outputs {rdy,mclk,lrck,sck,sdin,ur,cnt!=0} got %b expected 0000000", name, got);
    end
  endtask

  task automatic check_ready_after_release(input string name);
    n_cmp++;
    if (sample_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s: sample_ready got %b expected 1", name, sample_ready);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset        = 1'b0;
    sample_valid = 1'b0;
    audio_left   = 16'h0;
    audio_right  = 16'h0;
    repeat (4) @(negedge clk);
    check_all_zero("reset_hold");
    reset = 1'b1;
    #1;
    check_ready_after_release("reset_release_ready");
  endtask

  task automatic test_clocks();
    logic [31:0] c;
    logic [2:0]  exp_clk;
    logic        exp_ur;
    while (cyc < 2 * FRAME + 4) begin
      @(negedge clk);
      c = cyc;
      exp_clk = {c[MCLK_LOG2-1], c[SCK_LOG2-1], c[LRCK_LOG2-1]};
      exp_ur  = (cyc > 0) && ((cyc % FRAME) == 0);
      n_cmp += 3;
      if ({audio_mclk, audio_sck, audio_lrck} !== exp_clk) begin
        n_err++;
        $display("FAIL clocks cyc %0d: {mclk,sck,lrck} got %b expected %b", cyc,
                 {audio_mclk, audio_sck, audio_lrck}, exp_clk);
      end
      if (audio_sdin !== 1'b0) begin
        n_err++;
        $display("FAIL idle_sdin cyc %0d: got %b expected 0", cyc, audio_sdin);
      end
      if (underrun !== exp_ur) begin
        n_err++;
        $display("FAIL idle_underrun cyc %0d: got %b expected %b", cyc, underrun, exp_ur);
      end
    end
    check_cnt("idle_cnt", 8'd2);
  endtask

  task automatic test_single_sample();
    logic [15:0] l;
    logic [15:0] r;
    int          acc;
    l = 16'hA5C3;
    r = 16'h0F0F;
    push(l, r, acc);
    exp_q.push_back({1'b0, l, r[15:1]});
    exp_q.push_back({r[0], 31'h0});
    n_cmp++;
    if (sample_ready !== 1'b0) begin
      n_err++;
      $display("FAIL single_ready_full: sample_ready got %b expected 0", sample_ready);
    end
    check_frame("single_frame");
    check_cnt("single_no_underrun", 8'd2);
    check_frame("single_next_slot0");
    check_cnt("single_starved_after", 8'd3);
  endtask

  task automatic test_back_to_back();
    logic [15:0] al, ar, bl, br;
    logic [7:0]  cnt0;
    int          acc;
    al = 16'h1234; ar = 16'h8765;
    bl = 16'($urandom_range(0, 65535));
    br = 16'($urandom_range(0, 65535)) | 16'h0001;
    wait_div(SCK_PER / 2);
    cnt0 = underrun_cnt;
    push(al, ar, acc);
    exp_q.push_back({1'b0, al, ar[15:1]});
    push(bl, br, acc);
    exp_q.push_back({ar[0], bl, br[15:1]});
    n_cmp++;
    if (acc != FRAME - 1) begin
      n_err++;
      $display("FAIL b2b_accept_point: second accepted at divider %0d expected %0d", acc, FRAME - 1);
    end
    check_frame("b2b_first");
    check_frame("b2b_second");
    check_cnt("b2b_no_underrun", cnt0);
    // The frame after B starts starved; its slot 0 carries B's R[0].
    exp_q.push_back({br[0], 31'h0});
    check_frame("b2b_tail");
  endtask

  task automatic test_starve();
    for (int i = 0; i < 300; i++) begin
      exp_q.push_back(32'h0);
      check_frame("starve_frame");
    end
    check_cnt("starve_saturated", 8'hFF);
    wait_div(0);
    n_cmp++;
    if (underrun !== 1'b1) begin
      n_err++;
      $display("FAIL starve_pulse: underrun got %b expected 1", underrun);
    end
    check_cnt("starve_still_saturated", 8'hFF);
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] cl, cr;
    int          acc;
    cl = 16'hFFFF; cr = 16'h5A5A;
    wait_div(SCK_PER / 2);
    push(cl, cr, acc);
    push(16'hBEEF, 16'hCAFE, acc);
    wait_div(10 * SCK_PER + SCK_PER / 2);
    n_cmp++;
    if (audio_sdin !== cl[6]) begin
      n_err++;
      $display("FAIL midreset_slot10: sdin got %b expected %b", audio_sdin, cl[6]);
    end
    reset = 1'b0;
    #1;
    check_all_zero("midreset_immediate");
    repeat (3) @(negedge clk);
    check_all_zero("midreset_hold");
    reset = 1'b1;
    #1;
    check_ready_after_release("midreset_release_ready");
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    check_frame("midreset_first_frame");
    check_frame("midreset_held_dropped");
    check_cnt("midreset_cnt", 8'd1);
  endtask

`ifdef AUDIO_VOLUME_EN
  function automatic logic [15:0] vol_ref(input logic [15:0] x, input logic [2:0] v);
    logic [15:0] y;
    if (v == 3'd0) return 16'h0;
    y = x;
    for (int i = 0; i < 7 - int'(v); i++) y = {y[15], y[15:1]};
    return y;
  endfunction

  task automatic test_volume();
    logic [2:0]  vols[4];
    logic [15:0] l, r, el, er;
    int          acc;
    vols = '{3'd7, 3'd6, 3'd1, 3'd0};
    l = 16'hA5C3;
    r = 16'h7F01;
    for (int i = 0; i < 4; i++) begin
      wait_div(SCK_PER / 2);
      volume = vols[i];
      push(l, r, acc);
      el = vol_ref(l, vols[i]);
      er = vol_ref(r, vols[i]);
      exp_q.push_back({1'b0, el, er[15:1]});
      check_frame("volume_frame");
    end
  endtask
`endif

  initial begin
`ifdef AUDIO_VOLUME_EN
    volume = 3'd7;
`endif
    test_reset();
    test_clocks();
    test_single_sample();
    test_back_to_back();
    test_starve();
    test_reset_mid_frame();
`ifdef AUDIO_VOLUME_EN
    test_volume();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
